input_conditioner: RTL and testbench
====================================

# input_conditioner

Upstream conditioning stage for the sequence-detector FSM. It takes a raw, asynchronous, possibly bouncing input and produces a clean, CLK-synchronous level for the FSM's `In1`. The block uses a two-flop synchronizer and a four-state debounce machine with a confirmation counter. It also emits one-cycle edge pulses and a saturating glitch counter for diagnostics.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples required to accept a level change. Legal range 2..255.
- `CNT_W`, default 8: confirmation counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `CLK`  input  1  system clock, all logic on rising edge.
- `RST`  input  1  reset, asynchronous, active-high.
- `raw_in`  input  1  asynchronous raw signal (switch or pin).
- `en`  input  1  conditioning enable; when 0 the FSM and counter freeze.
- `level_out`  output  1  debounced level; drives downstream `In1`.
- `rise_pulse`  output  1  one-cycle pulse on an accepted 0→1 change.
- `fall_pulse`  output  1  one-cycle pulse on an accepted 1→0 change.
- `glitch_count`  output  8  saturating count of aborted confirmations.

## Operation
- **Synchronizer:** `sync1 <= raw_in`, then `sync_q <= sync1`. It runs every cycle regardless of `en`. Only `sync_q` feeds the FSM.
- **States:** `S_LOW`, `C_HIGH`, `S_HIGH`, `C_LOW`.
- **`S_LOW`:**
  - If `sync_q` = 1: go to `C_HIGH` and set `cnt` to 1.
  - Otherwise: stay.
- **`C_HIGH`:**
  - If `sync_q` = 0: return to `S_LOW`, clear `cnt`, increment `glitch_count`.
  - Else if `cnt` == DEBOUNCE_CYCLES-1: go to `S_HIGH`, set `level_out` to 1, assert `rise_pulse`, clear `cnt`.
  - Otherwise: increment `cnt`.
- **`S_HIGH` / `C_LOW`:** mirror of the above with polarity swapped. The confirmed transition sets `level_out` to 0 and asserts `fall_pulse`.
- **`level_out`:** registered. It equals 1 only in `S_HIGH` and `C_LOW`, and 0 only in `S_LOW` and `C_HIGH`.
- **Edge pulses:** registered and high for exactly one cycle. At most one pulse is high in any cycle.
- **`glitch_count`:** saturates at 255. It never wraps.
- **`en` = 0:** state, `cnt`, `level_out` and `glitch_count` hold their values. Both pulses are 0. Resuming with `en` = 1 continues from the held state and count.
- **Reset values:** state `S_LOW`; `sync1`, `sync_q`, `cnt` = 0; `level_out` = 0; `rise_pulse`, `fall_pulse` = 0; `glitch_count` = 0. A `level_out` of 0 keeps the downstream FSM in its idle state.
- **Illegal or unreachable state:** next state is `S_LOW`, `level_out` = 0, `cnt` = 0.

## Timing
- **Accepted change latency:** `raw_in` settles before edge r0. `sync_q` changes after edge r1. The FSM first samples the new value at edge r2. `level_out` and the matching pulse update after edge r2+DEBOUNCE_CYCLES-1.
  - This is DEBOUNCE_CYCLES+2 rising edges counted from r0.
  - With the default of 4, the output updates at the 6th edge.
- **Acceptance condition:** `sync_q` must hold the new value at DEBOUNCE_CYCLES consecutive enabled FSM samples.
- **Disabled cycles:** cycles with `en` = 0 do not count toward acceptance and do not break the run.
- **Shortest rejected glitch:** a `sync_q` excursion of 1 to DEBOUNCE_CYCLES-1 enabled cycles causes no change to `level_out` and increments `glitch_count` by 1.
- **Reset mid-confirmation:** asynchronous. All outputs go to their reset values immediately. No pulse is emitted.
- **Pulse vs level:** a pulse is asserted in the same cycle that `level_out` first shows the new value.

## Configuration
- Macro: `INPUT_COND_GLITCH_CNT_EN`.
- **Defined:** the glitch counter is implemented as described above.
- **Undefined:** the counter logic is compiled out and `glitch_count` is tied to 8'd0. The port remains present and all other behaviour is identical.

## Test plan
- **Reset:** assert `RST` mid-run with `raw_in` = 1. Required: `level_out`, pulses and `glitch_count` = 0 immediately; state `S_LOW` after release.
- **Clean rise:** `DEBOUNCE_CYCLES` = 4, `en` = 1, `raw_in` 0→1 before edge r0. Required: `level_out` = 1 and `rise_pulse` high for one cycle after edge r0+5, and not earlier.
- **Glitch rejection:** a 2-cycle high pulse on `raw_in`. Required: `level_out` stays 0 and `glitch_count` goes from 0 to 1. With the macro undefined, `glitch_count` stays 0.
- **Bounce:** `raw_in` toggles 1,0,1,0,1 then holds 1. Required: exactly one `rise_pulse`, and `glitch_count` = 2.
- **Enable freeze:** `raw_in` goes to 1, 2 enabled samples are taken, `en` = 0 for 10 cycles, then `en` = 1. Required: `level_out` rises after 2 more enabled samples, and no pulse occurs while `en` = 0.
- **Saturation:** apply 300 short glitches. Required: `glitch_count` = 255 and holds; a clean fall afterwards yields one `fall_pulse` and `level_out` = 0.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Signal bundle between a raw-input source and the input conditioner.
// master drives the raw level and enable; slave returns the conditioned outputs.
interface input_conditioner_if;
    logic       raw_in;
    logic       en;
    logic       level_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] glitch_count;

    modport master (
        output raw_in,
        output en,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  glitch_count
    );

    modport slave (
        input  raw_in,
        input  en,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output glitch_count
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizer plus debounce FSM producing a clean level, edge pulses and a glitch counter.
// Define INPUT_COND_GLITCH_CNT_EN to build the saturating glitch counter; otherwise it reads 0.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input logic              CLK,
    input logic              RST,
    input_conditioner_if.slave cond
);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        C_HIGH = 2'd1,
        S_HIGH = 2'd2,
        C_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 || (2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_param
        $error("input_conditioner: illegal DEBOUNCE_CYCLES/CNT_W combination");
    end

    logic             sync1;
    logic             sync_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    // Two-flop synchronizer, free-running regardless of enable
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1  <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            sync1  <= cond.raw_in;
            sync_q <= sync1;
        end
    end

    // State register, with the registered outputs derived from the next state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cond.en) begin
            case (state_q)
                S_LOW: begin
                    if (sync_q) begin
                        state_d = C_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                C_HIGH: begin
                    if (!sync_q) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!sync_q) begin
                        state_d = C_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
                C_LOW: begin
                    if (sync_q) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Pulses fire only on a confirmed transition, which can happen only while enabled
    always_comb begin
        level_d = (state_d == S_HIGH) || (state_d == C_LOW);
        rise_d  = cond.en && (state_q == C_HIGH) && (state_d == S_HIGH);
        fall_d  = cond.en && (state_q == C_LOW)  && (state_d == S_LOW);
    end

    assign cond.level_out  = level_q;
    assign cond.rise_pulse = rise_q;
    assign cond.fall_pulse = fall_q;

`ifdef INPUT_COND_GLITCH_CNT_EN
    logic [7:0] glitch_q;
    logic       glitch_evt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // An aborted confirmation is a return from a confirming state to the settled one
    assign glitch_evt = cond.en && (((state_q == C_HIGH) && !sync_q) ||
                                    ((state_q == C_LOW)  &&  sync_q));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            glitch_q <= 8'd0;
        end else if (glitch_evt) begin
            glitch_q <= sat_inc(glitch_q);
        end
    end

    assign cond.glitch_count = glitch_q;
`else
    assign cond.glitch_count = 8'd0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Randomized and directed bench for input_conditioner against a run-length reference model.
module tb_input_conditioner;

    localparam int D = 4;

    logic CLK;
    logic RST;
    input_conditioner_if bus ();

    input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .cond (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: sync pipeline as two bits, debounce as a run length
    logic m_sync1, m_syncq, m_level, m_rise, m_fall;
    int   m_run, m_glitch;
    int   n_rise, n_fall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int gexp(input int n);
`ifdef INPUT_COND_GLITCH_CNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic model_reset();
        m_sync1 = 0; m_syncq = 0; m_level = 0; m_rise = 0; m_fall = 0;
        m_run = 0; m_glitch = 0;
    endtask

    task automatic model_edge(input logic r, input logic e);
        m_rise = 0;
        m_fall = 0;
        if (e) begin
            if (m_syncq != m_level) begin
                m_run++;
                if (m_run == D) begin
                    m_level = m_syncq;
                    if (m_level) m_rise = 1; else m_fall = 1;
                    m_run = 0;
                end
            end else begin
                if (m_run > 0) m_glitch++;
                m_run = 0;
            end
        end
        m_syncq = m_sync1;
        m_sync1 = r;
    endtask

    task automatic step(input logic r, input logic e);
        bus.raw_in = r;
        bus.en     = e;
        @(posedge CLK);
        model_edge(r, e);
        #1;
        chk("level", bus.level_out, m_level);
        chk("rise", bus.rise_pulse, m_rise);
        chk("fall", bus.fall_pulse, m_fall);
        chk("glitch", bus.glitch_count, gexp(m_glitch));
        n_rise += int'(bus.rise_pulse);
        n_fall += int'(bus.fall_pulse);
    endtask

    task automatic hold(input logic r, input int n);
        for (int i = 0; i < n; i++) step(r, 1'b1);
    endtask

    initial begin
        int first;
        int g0;
        int len;
        logic r;

        n_rise = 0;
        n_fall = 0;
        RST = 1'b1;
        bus.raw_in = 1'b0;
        bus.en = 1'b0;
        model_reset();
        #3;
        chk("rst_level", bus.level_out, 0);
        chk("rst_pulses", {bus.rise_pulse, bus.fall_pulse}, 0);
        chk("rst_glitch", bus.glitch_count, 0);
        @(posedge CLK); @(posedge CLK);
        #3 RST = 1'b0;
        hold(0, 4);

        // Glitch rejection: 2-cycle high pulse
        hold(1, 2);
        hold(0, 6);
        chk("glitch_level", bus.level_out, 0);
        chk("glitch_cnt", bus.glitch_count, gexp(1));

        // Clean rise latency
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1, 1);
            if (bus.rise_pulse && first == 0) first = i;
        end
        chk("rise_lat", first, 6);
        chk("rise_level", bus.level_out, 1);

        // Clean fall, then bounce 1,0,1,0,1 and hold
        hold(0, 8);
        chk("fall_level", bus.level_out, 0);
        n_rise = 0;
        g0 = m_glitch;
        step(1, 1); step(0, 1); step(1, 1); step(0, 1);
        hold(1, 10);
        chk("bounce_rises", n_rise, 1);
        chk("bounce_glitch", bus.glitch_count, gexp(g0 + 2));
        chk("bounce_level", bus.level_out, 1);

        // Enable freeze: 2 enabled samples, 10 disabled cycles, then 2 more samples
        hold(0, 8);
        n_rise = 0;
        n_fall = 0;
        hold(1, 4);
        for (int i = 0; i < 10; i++) step(1, 0);
        chk("frz_pulses", n_rise + n_fall, 0);
        chk("frz_level", bus.level_out, 0);
        step(1, 1);
        chk("frz_lvl3", bus.level_out, 0);
        step(1, 1);
        chk("frz_rise", bus.rise_pulse, 1);
        chk("frz_lvl4", bus.level_out, 1);

        // Randomized runs with occasional disable
        for (int k = 0; k < 400; k++) begin
            r = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) step(r, ($urandom_range(0, 9) != 0));
        end

        // Saturation: 300 low glitches while settled high, then a clean fall
        hold(1, 10);
        for (int k = 0; k < 300; k++) begin
            hold(0, 2);
            hold(1, 2);
        end
        chk("sat_glitch", bus.glitch_count, gexp(300));
        chk("sat_level", bus.level_out, 1);
        n_fall = 0;
        hold(0, 10);
        chk("sat_falls", n_fall, 1);
        chk("sat_fall_lvl", bus.level_out, 0);
        chk("sat_hold", bus.glitch_count, gexp(300));

        // Reset mid-confirmation with raw_in high
        hold(1, 8);
        hold(0, 3);
        bus.raw_in = 1'b1;
        #2 RST = 1'b1;
        #1;
        chk("arst_level", bus.level_out, 0);
        chk("arst_pulses", {bus.rise_pulse, bus.fall_pulse}, 0);
        chk("arst_glitch", bus.glitch_count, 0);
        @(posedge CLK); @(posedge CLK);
        #1;
        chk("arst_hold", bus.level_out, 0);
        #2 RST = 1'b0;
        model_reset();
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1, 1);
            if (bus.rise_pulse && first == 0) first = i;
        end
        chk("arst_relat", first, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
